// File: rtl/tmod_monitor_pkg.sv
// Shared definitions for the tmod bus slave: opcodes, status codes, boolean
// constants, the monitor command FSM states and the reset-default constants.
package tmod_monitor_pkg;

  // Opcodes driven by the tmod master. Three bits leave room for codes that
  // the monitor does not recognise; those are acknowledged but have no effect.
  typedef enum logic [2:0] {
    RESET         = 3'd0,
    NOOP          = 3'd1,
    SET_FRQ       = 3'd2,
    SET_HIGH_TEMP = 3'd3
  } TMOD_OP;

  typedef enum logic [1:0] {
    TMOD_OK   = 2'd0,
    TMOD_BUSY = 2'd1,
    TMOD_ERR  = 2'd2
  } TMOD_STATUS;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Command FSM of the monitor: accept, apply, acknowledge.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    ACK  = 2'd2
  } TMOD_MON_STATE;

  // Operand / frequency register width on the tmod bus.
  localparam int TMOD_OPND_W = 8;

  // Reset defaults.
  localparam int               TMOD_DEF_PRESCALE = 1000;
  localparam logic [TMOD_OPND_W-1:0] TMOD_DEF_FRQ  = 8'd1;
  localparam logic [TMOD_OPND_W-1:0] TMOD_DEF_HIGH = 8'd80;
  localparam int               TMOD_DEF_HYST     = 2;

endpackage

// File: rtl/tmod_sample_timer.sv
// Sample-rate timer: a PRESCALE-cycle prescaler feeding a period counter.
// tick fires once every freq*PRESCALE cycles; freq==0 disables it and holds
// both counters at zero. clear restarts the period and suppresses any tick
// that would have fired on the same cycle.
import tmod_monitor_pkg::*;

module tmod_sample_timer #(
  parameter int PRESCALE = TMOD_DEF_PRESCALE,
  parameter int FW       = TMOD_OPND_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [FW-1:0] freq,
  input  logic          clear,
  output logic          tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_reg;
  logic [FW-1:0] cnt_reg;
  logic          enabled;
  logic          wrap;
  logic [FW-1:0] last_cnt;

  assign enabled  = (freq != '0);
  assign wrap     = enabled && (presc_reg == PRESC_MAX);
  assign last_cnt = freq - FW'(1);
  assign tick     = wrap && (cnt_reg == last_cnt) && !clear;

  // Prescaler and period counter; the period counter advances on each wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_reg <= '0;
      cnt_reg   <= '0;
    end else if (clear || !enabled) begin
      presc_reg <= '0;
      cnt_reg   <= '0;
    end else if (wrap) begin
      presc_reg <= '0;
      if (cnt_reg == last_cnt) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + FW'(1);
      end
    end else begin
      presc_reg <= presc_reg + PW'(1);
    end
  end

endmodule

// File: rtl/tmod_monitor.sv
// tmod bus slave: accepts configuration ops through an op/ready/valid
// handshake (IDLE -> EXEC -> ACK), samples temp_in at the programmed rate
// and raises alarm when the captured sample exceeds the high threshold.
// Build option: TMOD_ALARM_LATCH_EN makes alarm sticky once set (cleared only
// by reset or a RESET op); without it alarm clears with HYST hysteresis.
import tmod_monitor_pkg::*;

module tmod_monitor #(
  parameter int                     TW       = 8,
  parameter int                     PRESCALE = TMOD_DEF_PRESCALE,
  parameter logic [TMOD_OPND_W-1:0] DEF_FRQ  = TMOD_DEF_FRQ,
  parameter logic [TMOD_OPND_W-1:0] DEF_HIGH = TMOD_DEF_HIGH,
  parameter int                     HYST     = TMOD_DEF_HYST
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2:0]             op,
  input  logic [TMOD_OPND_W-1:0] opnd,
  output logic                   ready,
  output logic                   valid,
  input  logic [TW-1:0]          temp_in,
  output logic [TW-1:0]          temp_q,
  output logic                   sample_stb,
  output logic                   alarm
);

  localparam logic [TW:0] HYST_W = (TW + 1)'(HYST);

  TMOD_MON_STATE state_reg, state_next;
  logic          accept;

  TMOD_OP                   op_reg;
  logic [TMOD_OPND_W-1:0]   opnd_reg;
  logic [TMOD_OPND_W-1:0]   freq_reg;
  logic [TW-1:0]            high_reg;
  logic [TW-1:0]            temp_q_reg;
  logic                     stb_reg;
  logic                     alarm_reg;

  logic exec;
  logic do_frq;
  logic do_high;
  logic do_rst;
  logic tick;
  logic over;
  logic under;

  assign exec    = (state_reg == EXEC);
  assign do_frq  = exec && (op_reg == SET_FRQ);
  assign do_high = exec && (op_reg == SET_HIGH_TEMP);
  assign do_rst  = exec && (op_reg == RESET);

  assign ready      = (state_reg == IDLE);
  assign valid      = (state_reg == ACK);
  assign temp_q     = temp_q_reg;
  assign sample_stb = stb_reg;
  assign alarm      = alarm_reg;

  // Over-threshold and hysteresis-clear tests, done one bit wider so the sum cannot wrap.
  assign over  = (temp_q_reg > high_reg);
  assign under = (({1'b0, temp_q_reg} + HYST_W) <= {1'b0, high_reg});

  // SET_FRQ and RESET restart the sampling period; a tick on that cycle is lost.
  tmod_sample_timer #(
    .PRESCALE (PRESCALE),
    .FW       (TMOD_OPND_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .freq  (freq_reg),
    .clear (do_frq || do_rst),
    .tick  (tick)
  );

  // Command FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Command FSM next state: any non-NOOP op seen while idle starts a command.
  always_comb begin
    state_next = state_reg;
    accept     = FALSE;
    case (state_reg)
      IDLE: begin
        if (op != NOOP) begin
          state_next = EXEC;
          accept     = TRUE;
        end
      end
      EXEC:    state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the op so master-side changes during EXEC/ACK are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_reg   <= NOOP;
      opnd_reg <= '0;
    end else if (accept) begin
      op_reg   <= TMOD_OP'(op);
      opnd_reg <= opnd;
    end
  end

  // Configuration registers, written only in EXEC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      freq_reg <= DEF_FRQ;
      high_reg <= TW'(DEF_HIGH);
    end else if (do_rst) begin
      freq_reg <= DEF_FRQ;
      high_reg <= TW'(DEF_HIGH);
    end else if (do_frq) begin
      freq_reg <= opnd_reg;
    end else if (do_high) begin
      high_reg <= TW'(opnd_reg);
    end
  end

  // Capture temp_in on each tick and strobe sample_stb alongside the new value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      temp_q_reg <= '0;
      stb_reg    <= 1'b0;
    end else if (do_rst) begin
      temp_q_reg <= '0;
      stb_reg    <= 1'b0;
    end else if (tick) begin
      temp_q_reg <= temp_in;
      stb_reg    <= 1'b1;
    end else begin
      stb_reg    <= 1'b0;
    end
  end

  // Re-evaluate alarm from the fresh sample on the cycle after sample_stb.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alarm_reg <= 1'b0;
    end else if (do_rst) begin
      alarm_reg <= 1'b0;
    end else if (stb_reg) begin
`ifdef TMOD_ALARM_LATCH_EN
      if (over) begin
        alarm_reg <= 1'b1;
      end
`else
      if (over) begin
        alarm_reg <= 1'b1;
      end else if (under) begin
        alarm_reg <= 1'b0;
      end
`endif
    end
  end

`ifdef TMOD_ALARM_LATCH_EN
  // Sticky alarm never uses the hysteresis clear.
  logic unused_under;
  assign unused_under = under;
`endif

endmodule

// File: tb/tb_tmod_monitor.sv
// Directed bench for tmod_monitor (PRESCALE=4, HYST=2). A cycle-level
// behavioural model (elapsed-time sampler, countdown handshake) is checked
// against the DUT every cycle, alongside hand-computed literal checks.
// Honours TMOD_ALARM_LATCH_EN when the bundle is built with it.
import tmod_monitor_pkg::*;

module tb_tmod_monitor;

  localparam int P    = 4;
  localparam int HY   = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] op = NOOP;
  logic [7:0] opnd = 8'd0;
  logic [7:0] temp_in = 8'd0;
  logic       ready, valid, sample_stb, alarm;
  logic [7:0] temp_q;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 0;

  tmod_monitor #(
    .TW       (8),
    .PRESCALE (P),
    .DEF_FRQ  (8'd1),
    .DEF_HIGH (8'd80),
    .HYST     (HY)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .opnd       (opnd),
    .ready      (ready),
    .valid      (valid),
    .temp_in    (temp_in),
    .temp_q     (temp_q),
    .sample_stb (sample_stb),
    .alarm      (alarm)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout act=running req=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0d req=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_busy    = 0;   // cycles until ready again: 2 = exec, 1 = ack
  int         m_elapsed = 0;   // clocks since the sampling period restarted
  logic [2:0] m_op      = NOOP;
  int         m_opnd    = 0;
  int         m_freq    = 1;
  int         m_high    = 80;
  int         m_tq      = 0;
  bit         m_stb     = 0;
  bit         m_alarm   = 0;
  int         n_tq;
  bit         n_stb, n_alarm, m_tick;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 0; m_elapsed = 0; m_op = NOOP; m_opnd = 0;
      m_freq = 1; m_high = 80; m_tq = 0; m_stb = 0; m_alarm = 0;
    end else begin
      n_alarm = m_alarm;
      if (m_stb) begin
        if (m_tq > m_high) n_alarm = 1;
`ifndef TMOD_ALARM_LATCH_EN
        else if (m_tq + HY <= m_high) n_alarm = 0;
`endif
      end
      m_tick = 0;
      if (m_freq != 0) begin
        m_elapsed++;
        if (m_elapsed == m_freq * P) begin
          m_tick = 1;
          m_elapsed = 0;
        end
      end
      n_tq  = m_tick ? int'(temp_in) : m_tq;
      n_stb = m_tick;
      if (m_busy == 2) begin
        if (m_op == SET_FRQ) begin
          m_freq = m_opnd; m_elapsed = 0; n_stb = 0; n_tq = m_tq;
        end else if (m_op == RESET) begin
          m_freq = 1; m_high = 80; m_elapsed = 0; n_stb = 0; n_tq = 0; n_alarm = 0;
        end else if (m_op == SET_HIGH_TEMP) begin
          m_high = m_opnd;
        end
      end
      if (m_busy == 0) begin
        if (op != NOOP) begin
          m_op = op; m_opnd = opnd; m_busy = 2;
        end
      end else begin
        m_busy--;
      end
      m_tq = n_tq; m_stb = n_stb; m_alarm = n_alarm;
    end
  end

  // Compare DUT against the model shortly after every rising edge.
  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      chk("m_ready",  32'(ready),      32'(m_busy == 0));
      chk("m_valid",  32'(valid),      32'(m_busy == 1));
      chk("m_temp_q", 32'(temp_q),     32'(m_tq));
      chk("m_stb",    32'(sample_stb), 32'(m_stb));
      chk("m_alarm",  32'(alarm),      32'(m_alarm));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_stb(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_stb && n < limit);
    if (!sample_stb) n = -1;
  endtask

  task automatic wait_ready(input string name, input int limit);
    int n;
    n = 0;
    while (!ready && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(ready), 32'd1);
  endtask

  task automatic do_op(input logic [2:0] o, input logic [7:0] d);
    @(negedge clk);
    op = o; opnd = d;
    @(negedge clk);
    op = NOOP;
    wait_ready("op_ready_timeout", 10);
  endtask

  int n, vcnt, scnt;

  initial begin
    repeat (3) @(negedge clk);
    cmp_en = 1;
    // 1. reset state
    chk("rst_ready", 32'(ready), 1);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_alarm", 32'(alarm), 0);
    chk("rst_temp_q", 32'(temp_q), 0);
    chk("rst_stb", 32'(sample_stb), 0);
    reset = 1'b1;
    wait_stb(20, n);
    wait_stb(20, n);
    chk("def_period", n, 4);
    chk("model_def_high", m_high, 80);

    // 2. SET_FRQ 3 handshake timing
    @(negedge clk); op = SET_FRQ; opnd = 8'd3;
    @(negedge clk); op = NOOP;
    chk("t2_ready_low", 32'(ready), 0);
    chk("t2_valid_low", 32'(valid), 0);
    @(negedge clk);
    chk("t2_valid_high", 32'(valid), 1);
    @(negedge clk);
    chk("t2_valid_done", 32'(valid), 0);
    chk("t2_ready_back", 32'(ready), 1);
    chk("model_freq3", m_freq, 3);
    wait_stb(40, n);
    wait_stb(40, n);
    chk("frq3_period", n, 12);

    // 3. alarm set / hold / clear
    temp_in = 8'd81;
    wait_stb(40, n);
    chk("t3_q81", 32'(temp_q), 81);
    chk("t3_alarm_pre", 32'(alarm), 0);
    @(negedge clk);
    chk("t3_alarm_set", 32'(alarm), 1);
    temp_in = 8'd79;
    wait_stb(40, n);
    @(negedge clk);
    chk("t3_alarm_hold79", 32'(alarm), 1);
    temp_in = 8'd78;
    wait_stb(40, n);
    @(negedge clk);
`ifdef TMOD_ALARM_LATCH_EN
    chk("t3_alarm_latched78", 32'(alarm), 1);
`else
    chk("t3_alarm_clear78", 32'(alarm), 0);
`endif

    // 4. sampling disabled, then resumed
    do_op(SET_FRQ, 8'd0);
    temp_in = 8'd99;
    scnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (sample_stb) scnt++;
    end
    chk("t4_no_stb", scnt, 0);
    chk("t4_q_frozen", 32'(temp_q), 78);
    do_op(SET_FRQ, 8'd1);
    wait_stb(20, n);
    chk("t4_resume", 32'(n > 0), 1);
    chk("t4_q99", 32'(temp_q), 99);
    @(negedge clk);
    chk("t4_alarm99", 32'(alarm), 1);

    // 5. held op executes twice, then RESET op
    @(negedge clk); op = SET_HIGH_TEMP; opnd = 8'd50;
    vcnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (valid) vcnt++;
    end
    op = NOOP;
    repeat (4) begin
      @(negedge clk);
      if (valid) vcnt++;
    end
    chk("t5_two_valids", vcnt, 2);
    chk("model_high50", m_high, 50);
    do_op(RESET, 8'd0);
    chk("t5_q_zero", 32'(temp_q), 0);
    chk("t5_alarm_zero", 32'(alarm), 0);
    temp_in = 8'd80;
    wait_stb(20, n);
    chk("t5_q80", 32'(temp_q), 80);
    @(negedge clk);
    chk("t5_high_restored", 32'(alarm), 0);
    temp_in = 8'd81;
    wait_stb(20, n);
    @(negedge clk);
    chk("t5_alarm81", 32'(alarm), 1);

    // 6. reset during EXEC
    @(negedge clk); op = SET_FRQ; opnd = 8'd5;
    @(negedge clk);
    chk("t6_exec_ready", 32'(ready), 0);
    reset = 1'b0; op = NOOP;
    #1;
    chk("t6_async_ready", 32'(ready), 1);
    chk("t6_async_alarm", 32'(alarm), 0);
    chk("t6_async_q", 32'(temp_q), 0);
    vcnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (valid) vcnt++;
    end
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (valid) vcnt++;
    end
    chk("t6_no_valid", vcnt, 0);
    wait_stb(20, n);
    wait_stb(20, n);
    chk("t6_def_period", n, 4);

    repeat (2) @(negedge clk);
    cmp_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
